snake_game_ctrl: RTL and testbench
==================================

# snake_game_ctrl

Game-level sequencer for the snake datapath. It generates the periodic `update` strobe, captures player turn presses and food hits between strobes and presents them to the datapath as one-cycle `rotL`/`rotR`/`grow` qualifiers aligned with `update`. It checks the new head position against the playfield bounds after every move and runs the start / pause / game-over flow. It sits between the board button logic and the `snake` datapath, and also feeds score and level to the display.

## Interface
- `TICK_DIV`, default 12_500_000: clocks per move; must be ≥ 2; counter width `$clog2(TICK_DIV)`.
- `X_MIN`, default 144: leftmost legal head X.
- `X_MAX`, default 768: rightmost legal head X.
- `Y_MIN`, default 32: lowest legal head Y.
- `Y_MAX`, default 512: highest legal head Y.
- `SCORE_W`, default 8: score counter width.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low; low forces the reset state immediately.
- `start`  in  1  start button, synchronised level; rising edge used.
- `pause`  in  1  pause button, synchronised level; rising edge used.
- `btn_l`, `btn_r`  in  1 each  turn buttons, synchronised level; rising edges used.
- `food_hit`  in  1  one-cycle pulse, head is on food.
- `inc`  in  1  datapath level-complete flag.
- `head_x`, `head_y`  in  10 each  datapath head X_LEFT / Y_BOTTOM.
- `update`  out  1  one-cycle move strobe to datapath.
- `rotL`, `rotR`, `grow`  out  1 each  qualifiers; high only while `update` is high.
- `snake_rst`  out  1  one-cycle, active-high re-init pulse to datapath.
- `running`  out  1  high in RUN or CHECK.
- `game_over`  out  1  high in OVER.
- `score`  out  SCORE_W  food count.
- `level`  out  3  levels completed.

## Operation
- **States:** IDLE, RUN, CHECK, PAUSE, OVER.
- **Reset:** state IDLE. All outputs 0. Tick counter, pending latches and edge registers cleared. Edge-detect history registers reset to 1, so a button held through reset produces no edge.
- **IDLE / OVER:** a `start` edge causes the following:
  - `snake_rst` pulses for 1 cycle.
  - `score`, `level`, the tick counter and all pending latches clear.
  - The block goes to RUN.
  - Turn, food and pause edges are ignored in these states.
- **RUN:**
  - The tick counter increments each cycle.
  - When counter = TICK_DIV−1: `update` = 1, `rotL` = pend_l, `rotR` = pend_r, `grow` = pend_g. The counter wraps to 0, the latches clear, `score` += pend_g (saturating at all-ones), and the block goes to CHECK.
- **CHECK (one cycle):**
  - The counter keeps counting, so the update period is exactly TICK_DIV cycles.
  - Out of bounds means `head_x` < X_MIN, `head_x` > X_MAX, `head_y` < Y_MIN or `head_y` > Y_MAX. Comparisons are unsigned 10-bit. Out of bounds → OVER; otherwise → RUN.
  - If `inc` = 1, `level` += 1 (saturating at 7).
- **Turn latch:**
  - A `btn_l` edge sets pend_l = 1 and clears pend_r; `btn_r` is symmetric (latest press wins).
  - `btn_l` and `btn_r` edges in the same cycle clear both latches.
  - An edge in the `update` cycle applies to the next tick.
- **Food latch:** `food_hit` sets pend_g. A hit in the `update` cycle applies to the next tick.
- **Pause:**
  - A `pause` edge in RUN → PAUSE. A `pause` edge in CHECK is held and taken on the next RUN cycle.
  - In PAUSE the counter freezes, latches hold, and turn and food edges are ignored.
  - A `pause` edge in PAUSE → RUN with the counter resumed from its frozen value.
  - A `start` edge in PAUSE is ignored.
- **OVER:** `game_over` = 1; `score` and `level` hold until the next start.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Start edge sampled at clock edge k: `snake_rst` is high during cycle k+1, and RUN is entered with counter = 0 in that same cycle.
- The first `update` occurs TICK_DIV−1 cycles after the `snake_rst` cycle. Subsequent `update` strobes are every TICK_DIV cycles while unpaused.
- The datapath moves at the `update` edge. The block samples `head_*` and `inc` in the CHECK cycle, which is the cycle immediately after `update`.
- `game_over` rises in the cycle after CHECK. No `update` is issued after the fatal one.
- Reset asserted mid-game: outputs drop to 0 asynchronously and the block is in IDLE on release. No `snake_rst` is generated until the next `start` edge.

## Test plan
- **Basic tick** (TICK_DIV = 4, start pulse) → `snake_rst` one cycle, then `update` at 3, 7, 11 cycles after it, each exactly 1 cycle wide; `rotL`/`rotR`/`grow` stay 0.
- **Turn latch** (`btn_l` edge, then `btn_r` edge, both before a tick) → that tick has `rotR` = 1, `rotL` = 0. Simultaneous L/R edges → both 0. Edge in the `update` cycle → seen at the following tick only.
- **Food and score** (`food_hit` twice before one tick, once in an `update` cycle) → `grow` = 1 on that tick, `score` = 1. The next tick has `grow` = 1 and `score` = 2. With SCORE_W = 2 after 5 hits, `score` = 3.
- **Wall hit** (`head_x` = 784 presented in CHECK) → `game_over` = 1 next cycle, `update` never asserts again. `start` edge → `snake_rst`, `score` = 0, `game_over` = 0.
- **Pause** (pause edge at counter = 2, hold 20 cycles, pause again) → no `update` during PAUSE; `update` arrives 1 cycle after resume. Turn edge during PAUSE → not issued.
- **Level and reset** (`inc` = 1 in CHECK ×9) → `level` saturates at 7. `reset` low mid-RUN → all outputs 0 within the same cycle; after release the block is idle until `start`.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// Game-level sequencer for the snake datapath: move tick, turn/food qualifiers,
// bounds check and the start / pause / game-over flow. All outputs are registered.
module snake_game_ctrl #(
  parameter int unsigned TICK_DIV = 12_500_000,
  parameter int unsigned X_MIN    = 144,
  parameter int unsigned X_MAX    = 768,
  parameter int unsigned Y_MIN    = 32,
  parameter int unsigned Y_MAX    = 512,
  parameter int unsigned SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               btn_l,
  input  logic               btn_r,
  input  logic               food_hit,
  input  logic               inc,
  input  logic [9:0]         head_x,
  input  logic [9:0]         head_y,
  output logic               update,
  output logic               rotL,
  output logic               rotR,
  output logic               grow,
  output logic               snake_rst,
  output logic               running,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         level
);

  localparam int unsigned     CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [9:0]       XLO      = 10'(X_MIN);
  localparam logic [9:0]       XHI      = 10'(X_MAX);
  localparam logic [9:0]       YLO      = 10'(Y_MIN);
  localparam logic [9:0]       YHI      = 10'(Y_MAX);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_CHECK, S_PAUSE, S_OVER} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic               pend_g_q, pend_g_d, pend_p_q, pend_p_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         level_q, level_d;
  logic               start_q, pause_q, btn_l_q, btn_r_q;
  logic               update_q, update_d, rotl_q, rotl_d, rotr_q, rotr_d;
  logic               grow_q, grow_d, srst_q, srst_d;
  logic               running_q, running_d, over_q, over_d;
  logic               start_go;

  logic start_e, pause_e, l_e, r_e, pause_req, oob;
  assign start_e   = start & ~start_q;
  assign pause_e   = pause & ~pause_q;
  assign l_e       = btn_l & ~btn_l_q;
  assign r_e       = btn_r & ~btn_r_q;
  assign pause_req = pause_e | pend_p_q;
  assign oob       = (head_x < XLO) || (head_x > XHI) || (head_y < YLO) || (head_y > YHI);

  // Latest press wins; simultaneous opposite presses cancel each other.
  function automatic logic [1:0] turn_sel(input logic le, input logic re,
                                          input logic pl, input logic pr);
    if (le && re) return 2'b00;
    if (le)       return 2'b10;
    if (re)       return 2'b01;
    return {pl, pr};
  endfunction

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + SCORE_W'(1);
  endfunction

  function automatic logic [2:0] level_inc(input logic [2:0] l);
    return (l == 3'd7) ? l : l + 3'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_l_q  <= 1'b0;
      pend_r_q  <= 1'b0;
      pend_g_q  <= 1'b0;
      pend_p_q  <= 1'b0;
      score_q   <= '0;
      level_q   <= '0;
      start_q   <= 1'b1;
      pause_q   <= 1'b1;
      btn_l_q   <= 1'b1;
      btn_r_q   <= 1'b1;
      update_q  <= 1'b0;
      rotl_q    <= 1'b0;
      rotr_q    <= 1'b0;
      grow_q    <= 1'b0;
      srst_q    <= 1'b0;
      running_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_l_q  <= pend_l_d;
      pend_r_q  <= pend_r_d;
      pend_g_q  <= pend_g_d;
      pend_p_q  <= pend_p_d;
      score_q   <= score_d;
      level_q   <= level_d;
      start_q   <= start;
      pause_q   <= pause;
      btn_l_q   <= btn_l;
      btn_r_q   <= btn_r;
      update_q  <= update_d;
      rotl_q    <= rotl_d;
      rotr_q    <= rotr_d;
      grow_q    <= grow_d;
      srst_q    <= srst_d;
      running_q <= running_d;
      over_q    <= over_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;
    pend_g_d = pend_g_q;
    pend_p_d = pend_p_q;
    score_d  = score_q;
    level_d  = level_q;
    start_go = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_e) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          pend_l_d = 1'b0;
          pend_r_d = 1'b0;
          pend_g_d = 1'b0;
          pend_p_d = 1'b0;
          score_d  = '0;
          level_d  = '0;
          start_go = 1'b1;
        end
      end
      S_RUN: begin
        if (update_q) begin
          // Strobe cycle: latches restart from this cycle's presses only.
          state_d              = S_CHECK;
          cnt_d                = '0;
          score_d              = pend_g_q ? score_inc(score_q) : score_q;
          {pend_l_d, pend_r_d} = turn_sel(l_e, r_e, 1'b0, 1'b0);
          pend_g_d             = food_hit;
          pend_p_d             = pause_req;
        end else begin
          cnt_d                = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
          {pend_l_d, pend_r_d} = turn_sel(l_e, r_e, pend_l_q, pend_r_q);
          pend_g_d             = pend_g_q | food_hit;
          if (pause_req) begin
            state_d  = S_PAUSE;
            pend_p_d = 1'b0;
          end
        end
      end
      S_CHECK: begin
        cnt_d                = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        {pend_l_d, pend_r_d} = turn_sel(l_e, r_e, pend_l_q, pend_r_q);
        pend_g_d             = pend_g_q | food_hit;
        pend_p_d             = oob ? 1'b0 : pause_req;
        if (inc) level_d = level_inc(level_q);
        state_d = oob ? S_OVER : S_RUN;
      end
      S_PAUSE: begin
        if (pause_e) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so they are registered yet
  // line up with the cycle in which the counter sits at its last value.
  always_comb begin
    update_d  = (state_d == S_RUN) && (cnt_d == CNT_LAST) && !pend_p_d;
    rotl_d    = update_d & pend_l_d;
    rotr_d    = update_d & pend_r_d;
    grow_d    = update_d & pend_g_d;
    srst_d    = start_go;
    running_d = (state_d == S_RUN) || (state_d == S_CHECK);
    over_d    = (state_d == S_OVER);
  end

  assign update    = update_q;
  assign rotL      = rotl_q;
  assign rotR      = rotr_q;
  assign grow      = grow_q;
  assign snake_rst = srst_q;
  assign running   = running_q;
  assign game_over = over_q;
  assign score     = score_q;
  assign level     = level_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with TICK_DIV = 4: vector table for the
// tick / turn / food flow, then sequences for saturation, pause, wall hit and reset.
module tb_snake_game_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, pause, btn_l, btn_r, food_hit, inc;
  logic [9:0] head_x, head_y;
  logic       update, rotL, rotR, grow, snake_rst, running, game_over;
  logic [7:0] score;
  logic [2:0] level;
  logic       update_2, rotL_2, rotR_2, grow_2, snake_rst_2, running_2, game_over_2;
  logic [1:0] score_2;
  logic [2:0] level_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snake_game_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .btn_l(btn_l),
    .btn_r(btn_r), .food_hit(food_hit), .inc(inc), .head_x(head_x), .head_y(head_y),
    .update(update), .rotL(rotL), .rotR(rotR), .grow(grow), .snake_rst(snake_rst),
    .running(running), .game_over(game_over), .score(score), .level(level)
  );

  snake_game_ctrl #(.TICK_DIV(TD), .SCORE_W(2)) dut_s2 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .btn_l(btn_l),
    .btn_r(btn_r), .food_hit(food_hit), .inc(inc), .head_x(head_x), .head_y(head_y),
    .update(update_2), .rotL(rotL_2), .rotR(rotR_2), .grow(grow_2),
    .snake_rst(snake_rst_2), .running(running_2), .game_over(game_over_2),
    .score(score_2), .level(level_2)
  );

  // in = {start, pause, btn_l, btn_r, food_hit}
  // eo = {update, rotL, rotR, grow, snake_rst, running, game_over}
  typedef struct {
    logic [4:0] in;
    logic [6:0] eo;
    logic [7:0] esc;
  } vec_t;

  vec_t tbl[30];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_update(input int maxc);
    int n;
    n = 0;
    while (update !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    if (update !== 1'b1) begin
      errors++;
      $display("FAIL wait_update: got no update within %0d cycles expected update", maxc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [6:0] outs;
    int         seen;

    tbl[0]  = '{5'b00000, 7'b0000000, 8'd0};
    tbl[1]  = '{5'b10000, 7'b0000110, 8'd0};
    tbl[2]  = '{5'b00000, 7'b0000010, 8'd0};
    tbl[3]  = '{5'b00000, 7'b0000010, 8'd0};
    tbl[4]  = '{5'b00000, 7'b1000010, 8'd0};
    tbl[5]  = '{5'b00000, 7'b0000010, 8'd0};
    tbl[6]  = '{5'b00000, 7'b0000010, 8'd0};
    tbl[7]  = '{5'b00000, 7'b0000010, 8'd0};
    tbl[8]  = '{5'b00000, 7'b1000010, 8'd0};
    tbl[9]  = '{5'b00000, 7'b0000010, 8'd0};
    tbl[10] = '{5'b00000, 7'b0000010, 8'd0};
    tbl[11] = '{5'b00000, 7'b0000010, 8'd0};
    tbl[12] = '{5'b00000, 7'b1000010, 8'd0};
    tbl[13] = '{5'b00000, 7'b0000010, 8'd0};
    tbl[14] = '{5'b00100, 7'b0000010, 8'd0};
    tbl[15] = '{5'b00010, 7'b0000010, 8'd0};
    tbl[16] = '{5'b00000, 7'b1010010, 8'd0};
    tbl[17] = '{5'b00000, 7'b0000010, 8'd0};
    tbl[18] = '{5'b00100, 7'b0000010, 8'd0};
    tbl[19] = '{5'b00000, 7'b0000010, 8'd0};
    tbl[20] = '{5'b00110, 7'b1000010, 8'd0};
    tbl[21] = '{5'b00001, 7'b0000010, 8'd0};
    tbl[22] = '{5'b00001, 7'b0000010, 8'd0};
    tbl[23] = '{5'b00000, 7'b0000010, 8'd0};
    tbl[24] = '{5'b00000, 7'b1001010, 8'd0};
    tbl[25] = '{5'b00101, 7'b0000010, 8'd1};
    tbl[26] = '{5'b00000, 7'b0000010, 8'd1};
    tbl[27] = '{5'b00000, 7'b0000010, 8'd1};
    tbl[28] = '{5'b00000, 7'b1101010, 8'd1};
    tbl[29] = '{5'b00000, 7'b0000010, 8'd2};

    reset = 1'b0;
    {start, pause, btn_l, btn_r, food_hit, inc} = '0;
    head_x = 10'd400;
    head_y = 10'd200;
    tick();
    tick();
    chk("reset_outs", {update, rotL, rotR, grow, snake_rst, running, game_over}, 0);
    chk("reset_score_level", {score, level}, 0);
    #2 reset = 1'b1;

    for (int i = 0; i < 30; i++) begin
      {start, pause, btn_l, btn_r, food_hit} = tbl[i].in;
      tick();
      outs = {update, rotL, rotR, grow, snake_rst, running, game_over};
      checks++;
      if (outs !== tbl[i].eo || score !== tbl[i].esc) begin
        errors++;
        $display("FAIL row%0d: got outs=%b score=%0d expected outs=%b score=%0d",
                 i, outs, score, tbl[i].eo, tbl[i].esc);
      end
    end
    {start, pause, btn_l, btn_r, food_hit} = '0;

    // Three more food ticks: 8-bit score reaches 5, 2-bit score stops at 3.
    for (int k = 0; k < 3; k++) begin
      food_hit = 1'b1;
      tick();
      food_hit = 1'b0;
      wait_update(8);
      chk("food_grow", grow, 1);
      tick();
    end
    chk("score_8bit", score, 5);
    chk("score_2bit_sat", score_2, 3);

    // Nine level-complete flags in consecutive CHECK cycles.
    inc = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("level_step", level, (k + 1 < 7) ? k + 1 : 7);
      wait_update(8);
      tick();
    end
    inc = 1'b0;

    // Pause taken at counter 2, held 20 cycles with an ignored turn press.
    tick();
    tick();
    pause = 1'b1;
    tick();
    pause = 1'b0;
    chk("pause_running", running, 0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      btn_r = (k == 5);
      tick();
      if (update === 1'b1) seen++;
    end
    btn_r = 1'b0;
    chk("pause_no_update", seen, 0);
    pause = 1'b1;
    tick();
    pause = 1'b0;
    chk("resume_update", update, 1);
    chk("resume_rotR", rotR, 0);
    chk("resume_running", running, 1);
    tick();

    // Pause edge in CHECK is deferred to the next RUN cycle.
    pause = 1'b1;
    tick();
    pause = 1'b0;
    chk("held_pause_run", running, 1);
    tick();
    chk("held_pause_taken", running, 0);
    pause = 1'b1;
    tick();
    pause = 1'b0;
    chk("held_resume_noupd", update, 0);
    tick();
    chk("held_resume_update", update, 1);
    tick();

    // Wall hit: head_x past X_MAX is seen in the CHECK cycle.
    wait_update(8);
    head_x = 10'd784;
    tick();
    chk("wall_check_go", game_over, 0);
    tick();
    chk("wall_game_over", game_over, 1);
    chk("wall_running", running, 0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (update === 1'b1) seen++;
    end
    chk("over_no_update", seen, 0);
    chk("over_score_hold", score, 5);
    chk("over_level_hold", level, 7);
    head_x = 10'd400;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_snake_rst", snake_rst, 1);
    chk("restart_game_over", game_over, 0);
    chk("restart_score", score, 0);
    chk("restart_level", level, 0);

    // Asynchronous reset mid-run, with start held through release.
    tick();
    tick();
    chk("pre_reset_running", running, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outs", {update, rotL, rotR, grow, snake_rst, running, game_over}, 0);
    start = 1'b1;
    tick();
    #2 reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (snake_rst === 1'b1 || running === 1'b1 || update === 1'b1) seen++;
    end
    chk("held_start_no_edge", seen, 0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_reset_start", snake_rst, 1);
    tick();
    chk("snake_rst_width", snake_rst, 0);
    chk("post_reset_running", running, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
